usb_xbar_arbiter: RTL and testbench

//  Owns the 16-bit route select of the USB-to-parser crossbar (5 USB hosts -> 4 parsers).

---
 rtl/usb_xbar_arbiter_pkg.sv | 23 ++
 rtl/usb_xbar_arbiter_if.sv | 17 +
 rtl/usb_xbar_arbiter_slot.sv | 74 +++++++
 rtl/usb_xbar_arbiter.sv | 40 ++++
 tb/tb_usb_xbar_arbiter.sv | 165 ++++++++++++++++
 5 files changed

// File: rtl/usb_xbar_arbiter_pkg.sv
// usb_xbar_arbiter_pkg: shared sizes, idle select code, slot state type and round-robin pick helper
package usb_xbar_arbiter_pkg;

    localparam int NUM_HOSTS   = 5;
    localparam int NUM_PARSERS = 4;
    localparam int HOST_W      = 3;
    localparam logic [HOST_W-1:0] SEL_IDLE = 3'd7;

    typedef enum logic {S_IDLE, S_OWNED} slot_state_e;

    // First eligible host at or after ptr (mod NUM_HOSTS); SEL_IDLE when none
    function automatic logic [HOST_W-1:0] rr_pick(input logic [NUM_HOSTS-1:0] elig, input logic [HOST_W-1:0] ptr);
        logic [HOST_W-1:0] pick;
        logic [HOST_W-1:0] idx;
        pick = SEL_IDLE;
        for (int i = NUM_HOSTS - 1; i >= 0; i--) begin
            idx = HOST_W'((int'(ptr) + i) % NUM_HOSTS);
            if (elig[idx]) pick = idx;
        end
        return pick;
    endfunction

endpackage

// File: rtl/usb_xbar_arbiter_if.sv
// usb_xbar_arbiter_if: host request/release/activity inputs and crossbar select/status outputs
interface usb_xbar_arbiter_if;
    import usb_xbar_arbiter_pkg::*;

    logic [NUM_HOSTS-1:0]     req;
    logic [2*NUM_HOSTS-1:0]   req_parser;
    logic [NUM_HOSTS-1:0]     rel;
    logic [NUM_HOSTS-1:0]     dv;
    logic [4*NUM_PARSERS-1:0] sel;
    logic [NUM_HOSTS-1:0]     grant;
    logic [NUM_PARSERS-1:0]   busy;
    logic [NUM_PARSERS-1:0]   timeout_evt;

    modport master (output req, req_parser, rel, dv, input sel, grant, busy, timeout_evt);
    modport slave (input req, req_parser, rel, dv, output sel, grant, busy, timeout_evt);

endinterface

// File: rtl/usb_xbar_arbiter_slot.sv
// usb_xbar_slot: one parser's owner FSM with round-robin arbiter, idle counter and timeout pulse
module usb_xbar_slot
    import usb_xbar_arbiter_pkg::*;
#(
    parameter int TIMEOUT = 1024,
    parameter int TO_W    = 11
) (
    input  logic                 c,
    input  logic                 r_n,
    input  logic [NUM_HOSTS-1:0] elig_i,
    input  logic [NUM_HOSTS-1:0] rel_i,
    input  logic [NUM_HOSTS-1:0] dv_i,
    output logic [HOST_W-1:0]    owner_o,
    output logic                 busy_o,
    output logic [NUM_HOSTS-1:0] grant_o,
    output logic                 timeout_evt_o
);

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    slot_state_e       state_q, state_d;
    logic [HOST_W-1:0] owner_q, owner_d, ptr_q, ptr_d, win;
    logic [TO_W-1:0]   cnt_q, cnt_d;
    logic              tevt_q, tevt_d, owned, rel_own, dv_own, to_hit;

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        tevt_d  = 1'b0;
        owned   = state_q == S_OWNED;
        win     = rr_pick(elig_i, ptr_q);
        rel_own = owned && rel_i[owner_q];
        dv_own  = owned && dv_i[owner_q];
        // Count of TIMEOUT is reached on this edge: release instead of storing it
        to_hit  = owned && !dv_own && cnt_q == TO_LAST;
        if (!owned && win != SEL_IDLE) begin
            state_d = S_OWNED;
            owner_d = win;
            ptr_d   = (win == HOST_W'(NUM_HOSTS - 1)) ? '0 : win + 3'd1;
            cnt_d   = '0;
        end else if (rel_own || to_hit) begin
            state_d = S_IDLE;
            owner_d = SEL_IDLE;
            cnt_d   = '0;
            tevt_d  = !rel_own;
        end else if (owned) begin
            cnt_d   = dv_own ? '0 : cnt_q + TO_W'(1);
        end
    end

    always_ff @(posedge c) begin
        if (!r_n) begin
            state_q <= S_IDLE;
            owner_q <= SEL_IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            tevt_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            tevt_q  <= tevt_d;
        end
    end

    assign owner_o       = owner_q;
    assign busy_o        = state_q == S_OWNED;
    assign grant_o       = busy_o ? NUM_HOSTS'(1) << owner_q : '0;
    assign timeout_evt_o = tevt_q;

endmodule

// File: rtl/usb_xbar_arbiter.sv
// usb_xbar_arbiter: route-select owner for the 5-host to 4-parser USB crossbar
module usb_xbar_arbiter
    import usb_xbar_arbiter_pkg::*;
#(
    parameter int TIMEOUT = 1024,
    parameter int TO_W    = 11
) (
    input  logic           c,
    input  logic           r_n,
    usb_xbar_arbiter_if.slave bus
);

    logic [NUM_PARSERS-1:0][NUM_HOSTS-1:0] elig, sgrant;
    logic [NUM_PARSERS-1:0][HOST_W-1:0]    owner;

    for (genvar p = 0; p < NUM_PARSERS; p++) begin : g_slot
        // Owning hosts are excluded so a host never holds two parsers
        for (genvar h = 0; h < NUM_HOSTS; h++) begin : g_host
            assign elig[p][h] = bus.req[h] && bus.req_parser[2*h +: 2] == 2'(p) && !bus.grant[h];
        end
        usb_xbar_slot #(.TIMEOUT(TIMEOUT), .TO_W(TO_W)) u_slot (
            .c            (c),
            .r_n          (r_n),
            .elig_i       (elig[p]),
            .rel_i        (bus.rel),
            .dv_i         (bus.dv),
            .owner_o      (owner[p]),
            .busy_o       (bus.busy[p]),
            .grant_o      (sgrant[p]),
            .timeout_evt_o(bus.timeout_evt[p])
        );
        assign bus.sel[4*p +: 4] = {1'b0, owner[p]};
    end

    always_comb begin
        bus.grant = '0;
        for (int p = 0; p < NUM_PARSERS; p++) bus.grant |= sgrant[p];
    end

endmodule

// File: tb/tb_usb_xbar_arbiter.sv
// tb_usb_xbar_arbiter: directed scoreboard bench for the crossbar route arbiter (TIMEOUT=16)
module tb_usb_xbar_arbiter;

    typedef struct {
        string       tag;
        logic [15:0] sel;
        logic [4:0]  grant;
        logic [3:0]  busy;
        logic [3:0]  tevt;
    } exp_t;

    logic c, r_n;
    int   checks = 0;
    int   fails  = 0;
    exp_t sb[$];

    usb_xbar_arbiter_if bus();

    usb_xbar_arbiter #(.TIMEOUT(16), .TO_W(5)) dut (.c(c), .r_n(r_n), .bus(bus));

    initial c = 1'b0;
    always #5 c = ~c;

    task automatic step(input string tag, input logic [15:0] s, input logic [4:0] g,
                        input logic [3:0] b, input logic [3:0] t);
        exp_t e;
        sb.push_back('{tag, s, g, b, t});
        @(posedge c);
        #1;
        e = sb.pop_front();
        checks++;
        assert (bus.sel === e.sel) else begin
            fails++;
            $error("FAIL %s sel got %h exp %h", e.tag, bus.sel, e.sel);
        end
        checks++;
        assert (bus.grant === e.grant) else begin
            fails++;
            $error("FAIL %s grant got %b exp %b", e.tag, bus.grant, e.grant);
        end
        checks++;
        assert (bus.busy === e.busy) else begin
            fails++;
            $error("FAIL %s busy got %b exp %b", e.tag, bus.busy, e.busy);
        end
        checks++;
        assert (bus.timeout_evt === e.tevt) else begin
            fails++;
            $error("FAIL %s timeout_evt got %b exp %b", e.tag, bus.timeout_evt, e.tevt);
        end
    endtask

    initial begin
        r_n = 1'b0;
        bus.req = '0;
        bus.req_parser = '0;
        bus.rel = '0;
        bus.dv = '0;
        #1;
        step("reset", 16'h7777, 5'b00000, 4'b0000, 4'b0000);
        r_n = 1'b1;
        step("idle", 16'h7777, 5'b00000, 4'b0000, 4'b0000);
        step("idle2", 16'h7777, 5'b00000, 4'b0000, 4'b0000);

        // Host 2 -> parser 1, one registered stage
        bus.req[2] = 1'b1;
        bus.req_parser[5:4] = 2'd1;
        bus.dv[2] = 1'b1;
        step("h2_p1_grant", 16'h7727, 5'b00100, 4'b0010, 4'b0000);

        // Owning host 2 asks for parser 2: ignored until it releases
        bus.req_parser[5:4] = 2'd2;
        repeat (2) step("h2_p2_ignored", 16'h7727, 5'b00100, 4'b0010, 4'b0000);
        bus.rel[2] = 1'b1;
        step("h2_rel", 16'h7777, 5'b00000, 4'b0000, 4'b0000);
        bus.rel[2] = 1'b0;
        step("h2_p2_grant", 16'h7277, 5'b00100, 4'b0100, 4'b0000);
        bus.req[2] = 1'b0;
        bus.rel[2] = 1'b1;
        step("h2_rel2", 16'h7777, 5'b00000, 4'b0000, 4'b0000);
        bus.rel[2] = 1'b0;

        // Reset mid-ownership
        bus.req[2] = 1'b1;
        bus.req_parser[5:4] = 2'd1;
        step("h2_regrant", 16'h7727, 5'b00100, 4'b0010, 4'b0000);
        bus.req[2] = 1'b0;
        r_n = 1'b0;
        step("reset_mid", 16'h7777, 5'b00000, 4'b0000, 4'b0000);
        r_n = 1'b1;
        bus.dv = '0;

        // Hosts 0,3,4 contend for parser 0
        bus.req = 5'b11001;
        bus.req_parser = '0;
        bus.dv = 5'b11001;
        step("rr_h0", 16'h7770, 5'b00001, 4'b0001, 4'b0000);
        repeat (4) step("rr_h0_hold", 16'h7770, 5'b00001, 4'b0001, 4'b0000);
        bus.rel[0] = 1'b1;
        step("rr_h0_rel", 16'h7777, 5'b00000, 4'b0000, 4'b0000);
        bus.rel[0] = 1'b0;
        step("rr_h3", 16'h7773, 5'b01000, 4'b0001, 4'b0000);
        repeat (4) step("rr_h3_hold", 16'h7773, 5'b01000, 4'b0001, 4'b0000);
        bus.rel[3] = 1'b1;
        bus.req[3] = 1'b0;
        step("rr_h3_rel", 16'h7777, 5'b00000, 4'b0000, 4'b0000);
        bus.rel[3] = 1'b0;
        step("rr_h4", 16'h7774, 5'b10000, 4'b0001, 4'b0000);
        repeat (4) step("rr_h4_hold", 16'h7774, 5'b10000, 4'b0001, 4'b0000);
        bus.rel[4] = 1'b1;
        bus.req[4] = 1'b0;
        step("rr_h4_rel", 16'h7777, 5'b00000, 4'b0000, 4'b0000);
        bus.rel[4] = 1'b0;
        step("rr_h0_again", 16'h7770, 5'b00001, 4'b0001, 4'b0000);
        bus.req[0] = 1'b0;
        bus.rel[0] = 1'b1;
        step("rr_h0_rel2", 16'h7777, 5'b00000, 4'b0000, 4'b0000);
        bus.rel[0] = 1'b0;

        // Release by host 4 and request by host 0 on parser 2 in the same cycle
        bus.req[4] = 1'b1;
        bus.req_parser[9:8] = 2'd2;
        step("h4_p2_grant", 16'h7477, 5'b10000, 4'b0100, 4'b0000);
        bus.req[4] = 1'b0;
        step("h4_p2_hold", 16'h7477, 5'b10000, 4'b0100, 4'b0000);
        bus.rel[4] = 1'b1;
        bus.req[0] = 1'b1;
        bus.req_parser[1:0] = 2'd2;
        step("rel_wins", 16'h7777, 5'b00000, 4'b0000, 4'b0000);
        bus.rel[4] = 1'b0;
        step("h0_p2_grant", 16'h7077, 5'b00001, 4'b0100, 4'b0000);
        bus.req[0] = 1'b0;
        bus.rel[0] = 1'b1;
        step("h0_p2_rel", 16'h7777, 5'b00000, 4'b0000, 4'b0000);
        bus.rel[0] = 1'b0;
        bus.dv = '0;

        // Host 1 on parser 3 with no activity; dv pulse 15 cycles in restarts the count
        bus.req[1] = 1'b1;
        bus.req_parser[3:2] = 2'd3;
        step("h1_p3_grant", 16'h1777, 5'b00010, 4'b1000, 4'b0000);
        bus.req[1] = 1'b0;
        repeat (14) step("to_wait_a", 16'h1777, 5'b00010, 4'b1000, 4'b0000);
        bus.dv[1] = 1'b1;
        step("to_dv_pulse", 16'h1777, 5'b00010, 4'b1000, 4'b0000);
        bus.dv[1] = 1'b0;
        repeat (15) step("to_wait_b", 16'h1777, 5'b00010, 4'b1000, 4'b0000);
        step("to_fire", 16'h7777, 5'b00000, 4'b0000, 4'b1000);
        step("to_pulse_end", 16'h7777, 5'b00000, 4'b0000, 4'b0000);

        // Release coinciding with the timeout edge suppresses the pulse
        bus.req[1] = 1'b1;
        step("h1_regrant", 16'h1777, 5'b00010, 4'b1000, 4'b0000);
        bus.req[1] = 1'b0;
        repeat (15) step("to_wait_c", 16'h1777, 5'b00010, 4'b1000, 4'b0000);
        bus.rel[1] = 1'b1;
        step("rel_at_timeout", 16'h7777, 5'b00000, 4'b0000, 4'b0000);
        bus.rel[1] = 1'b0;
        step("final_idle", 16'h7777, 5'b00000, 4'b0000, 4'b0000);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
